axi_rd_router: RTL and testbench

//  Parametrised AXI4 read-channel router: one upstream master port to NUM_SLAVES downstream slaves.

---
 rtl/axi_rd_router.sv | 187 ++++++++++++++++++
 tb/tb_axi_rd_router.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_router.sv
// axi_rd_router: AXI4 read-channel router, one upstream master to NUM_SLAVES slaves.
// The slave is chosen from araddr[SEL_LSB +: SEL_W]. Each AR is registered, forwarded
// to the decoded slave, and the R path is then locked to that slave until RLAST.
// Only one burst is outstanding at a time.
// Optional feature macro: AXI_RD_ROUTER_DECERR_EN
//   defined   -> unmapped indices get an internal DECERR burst (arlen+1 beats)
//   undefined -> unmapped indices are routed to the last slave (NUM_SLAVES-1)
module axi_rd_router #(
  parameter int NUM_SLAVES = 4,
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SEL_LSB    = 28,
  parameter int SEL_W      = 3
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [ID_W-1:0]            us_arid,
  input  logic [ADDR_W-1:0]          us_araddr,
  input  logic [7:0]                 us_arlen,
  input  logic [2:0]                 us_arsize,
  input  logic [1:0]                 us_arburst,
  input  logic                       us_arvalid,
  output logic                       us_arready,
  output logic [ID_W-1:0]            us_rid,
  output logic [DATA_W-1:0]          us_rdata,
  output logic [1:0]                 us_rresp,
  output logic                       us_rlast,
  output logic                       us_rvalid,
  input  logic                       us_rready,
  output logic [ID_W-1:0]            ds_arid,
  output logic [ADDR_W-1:0]          ds_araddr,
  output logic [7:0]                 ds_arlen,
  output logic [2:0]                 ds_arsize,
  output logic [1:0]                 ds_arburst,
  output logic [NUM_SLAVES-1:0]      ds_arvalid,
  input  logic [NUM_SLAVES-1:0]      ds_arready,
  input  logic [NUM_SLAVES*ID_W-1:0] ds_rid,
  input  logic [NUM_SLAVES*DATA_W-1:0] ds_rdata,
  input  logic [NUM_SLAVES*2-1:0]    ds_rresp,
  input  logic [NUM_SLAVES-1:0]      ds_rlast,
  input  logic [NUM_SLAVES-1:0]      ds_rvalid,
  output logic [NUM_SLAVES-1:0]      ds_rready,
  output logic                       busy
);

  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [SEL_W:0] NUM_S = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [SW-1:0]  DEF_SLAVE = SW'(NUM_SLAVES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   cap_id;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_len;
  logic [2:0]        cap_size;
  logic [1:0]        cap_burst;
  logic [SW-1:0]     sel;
  logic [SEL_W-1:0]  idx;
  logic              mapped;
`ifdef AXI_RD_ROUTER_DECERR_EN
  logic [7:0]        cnt;
`endif

  assign idx    = us_araddr[SEL_LSB +: SEL_W];
  assign mapped = ({1'b0, idx} < NUM_S);

  // The downstream AR fields are the capture registers, broadcast to every slave.
  assign ds_arid    = cap_id;
  assign ds_araddr  = cap_addr;
  assign ds_arlen   = cap_len;
  assign ds_arsize  = cap_size;
  assign ds_arburst = cap_burst;

  // State register, AR capture and (optionally) the DECERR beat counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      cap_id    <= '0;
      cap_addr  <= '0;
      cap_len   <= 8'd0;
      cap_size  <= 3'd0;
      cap_burst <= 2'd0;
      sel       <= '0;
`ifdef AXI_RD_ROUTER_DECERR_EN
      cnt       <= 8'd0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && us_arvalid) begin
        cap_id    <= us_arid;
        cap_addr  <= us_araddr;
        cap_len   <= us_arlen;
        cap_size  <= us_arsize;
        cap_burst <= us_arburst;
        sel       <= mapped ? SW'(idx) : DEF_SLAVE;
      end
`ifdef AXI_RD_ROUTER_DECERR_EN
      if (state == ERR && us_rready) begin
        if (cnt == cap_len) begin
          cnt <= 8'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
`endif
    end
  end

  // Next-state decode and handshake/R-path muxing; everything is forced low during reset.
  always_comb begin
    state_nxt  = state;
    us_arready = 1'b0;
    us_rid     = '0;
    us_rdata   = '0;
    us_rresp   = 2'b00;
    us_rlast   = 1'b0;
    us_rvalid  = 1'b0;
    ds_arvalid = '0;
    ds_rready  = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        us_arready = 1'b1;
        if (us_arvalid) begin
`ifdef AXI_RD_ROUTER_DECERR_EN
          state_nxt = mapped ? ADDR : ERR;
`else
          state_nxt = ADDR;
`endif
        end
      end
      ADDR: begin
        ds_arvalid[sel] = 1'b1;
        if (ds_arready[sel]) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        us_rid          = ds_rid[sel*ID_W +: ID_W];
        us_rdata        = ds_rdata[sel*DATA_W +: DATA_W];
        us_rresp        = ds_rresp[sel*2 +: 2];
        us_rlast        = ds_rlast[sel];
        us_rvalid       = ds_rvalid[sel];
        ds_rready[sel]  = us_rready;
        if (us_rvalid && us_rready && us_rlast) begin
          state_nxt = IDLE;
        end
      end
`ifdef AXI_RD_ROUTER_DECERR_EN
      ERR: begin
        us_rvalid = 1'b1;
        us_rid    = cap_id;
        us_rresp  = 2'b11;
        us_rlast  = (cnt == cap_len);
        if (us_rready && us_rlast) begin
          state_nxt = IDLE;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (areset) begin
      us_arready = 1'b0;
      us_rid     = '0;
      us_rdata   = '0;
      us_rresp   = 2'b00;
      us_rlast   = 1'b0;
      us_rvalid  = 1'b0;
      ds_arvalid = '0;
      ds_rready  = '0;
      busy       = 1'b0;
    end else begin
      busy = busy;
    end
  end

endmodule

// File: tb/tb_axi_rd_router.sv
// Directed self-checking bench for axi_rd_router (NUM_SLAVES=4, default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_axi_rd_router;

  logic         aclk = 1'b0;
  logic         areset;
  logic [3:0]   us_arid;
  logic [31:0]  us_araddr;
  logic [7:0]   us_arlen;
  logic [2:0]   us_arsize;
  logic [1:0]   us_arburst;
  logic         us_arvalid;
  logic         us_arready;
  logic [3:0]   us_rid;
  logic [31:0]  us_rdata;
  logic [1:0]   us_rresp;
  logic         us_rlast;
  logic         us_rvalid;
  logic         us_rready;
  logic [3:0]   ds_arid;
  logic [31:0]  ds_araddr;
  logic [7:0]   ds_arlen;
  logic [2:0]   ds_arsize;
  logic [1:0]   ds_arburst;
  logic [3:0]   ds_arvalid;
  logic [3:0]   ds_arready;
  logic [15:0]  ds_rid;
  logic [127:0] ds_rdata;
  logic [7:0]   ds_rresp;
  logic [3:0]   ds_rlast;
  logic [3:0]   ds_rvalid;
  logic [3:0]   ds_rready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int beats;

  always #5 aclk = ~aclk;

  axi_rd_router dut (
    .aclk(aclk), .areset(areset),
    .us_arid(us_arid), .us_araddr(us_araddr), .us_arlen(us_arlen),
    .us_arsize(us_arsize), .us_arburst(us_arburst), .us_arvalid(us_arvalid),
    .us_arready(us_arready), .us_rid(us_rid), .us_rdata(us_rdata),
    .us_rresp(us_rresp), .us_rlast(us_rlast), .us_rvalid(us_rvalid),
    .us_rready(us_rready), .ds_arid(ds_arid), .ds_araddr(ds_araddr),
    .ds_arlen(ds_arlen), .ds_arsize(ds_arsize), .ds_arburst(ds_arburst),
    .ds_arvalid(ds_arvalid), .ds_arready(ds_arready), .ds_rid(ds_rid),
    .ds_rdata(ds_rdata), .ds_rresp(ds_rresp), .ds_rlast(ds_rlast),
    .ds_rvalid(ds_rvalid), .ds_rready(ds_rready), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_slaves();
    ds_arready = 4'b0000;
    ds_rid     = 16'h0000;
    ds_rdata   = 128'h0;
    ds_rresp   = 8'h00;
    ds_rlast   = 4'b0000;
    ds_rvalid  = 4'b0000;
  endtask

  // Upstream AR handshake followed by the downstream AR phase toward the slave in exp_v.
  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [3:0] exp_v);
    us_arid = id; us_araddr = addr; us_arlen = len;
    us_arsize = 3'd2; us_arburst = 2'b01; us_arvalid = 1'b1;
    @(negedge aclk);
    check("ar_ready_idle", {63'd0, us_arready}, 64'd1);
    step();
    us_arvalid = 1'b0;
    ds_rvalid  = 4'b1111;
    @(negedge aclk);
    check("ds_arvalid", {60'd0, ds_arvalid}, {60'd0, exp_v});
    check("ds_araddr", {32'd0, ds_araddr}, {32'd0, addr});
    check("ds_arlen", {56'd0, ds_arlen}, {56'd0, len});
    check("ar_ready_busy", {63'd0, us_arready}, 64'd0);
    check("rvalid_gated", {63'd0, us_rvalid}, 64'd0);
    ds_rvalid  = 4'b0000;
    ds_arready = exp_v;
    step();
    ds_arready = 4'b0000;
  endtask

  initial begin
    areset = 1'b1;
    us_arid = 4'h0; us_araddr = 32'h0; us_arlen = 8'd0;
    us_arsize = 3'd0; us_arburst = 2'b00; us_arvalid = 1'b1; us_rready = 1'b0;
    clear_slaves();

    // Reset held three cycles with arvalid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("rst_arready", {63'd0, us_arready}, 64'd0);
      check("rst_arvalid", {60'd0, ds_arvalid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      step();
    end
    areset = 1'b0;
    us_arvalid = 1'b0;
    @(negedge aclk);
    check("rel_arready", {63'd0, us_arready}, 64'd1);
    check("rel_busy", {63'd0, busy}, 64'd0);
    check("rel_rdata", {32'd0, us_rdata}, 64'd0);
    step();

    // Single read to slave 2
    do_ar(4'h5, 32'h2000_0010, 8'd0, 4'b0100);
    ds_rvalid = 4'b0100; ds_rlast = 4'b0100;
    ds_rdata[2*32 +: 32] = 32'hCAFE_0001; ds_rid[2*4 +: 4] = 4'h5;
    us_rready = 1'b1;
    @(negedge aclk);
    check("s2_rvalid", {63'd0, us_rvalid}, 64'd1);
    check("s2_rdata", {32'd0, us_rdata}, 64'hCAFE_0001);
    check("s2_rid", {60'd0, us_rid}, 64'h5);
    check("s2_rlast", {63'd0, us_rlast}, 64'd1);
    check("s2_rready", {60'd0, ds_rready}, 64'h4);
    step();
    clear_slaves();
    @(negedge aclk);
    check("s2_idle_busy", {63'd0, busy}, 64'd0);
    check("s2_idle_arready", {63'd0, us_arready}, 64'd1);
    step();

    // Eight-beat burst to slave 0 with us_rready toggling
    do_ar(4'h1, 32'h0000_0100, 8'd7, 4'b0001);
    beats = 0;
    ds_rvalid = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      ds_rdata[31:0] = 32'h1000_0000 + i;
      ds_rlast[0] = (i == 7);
      us_rready = 1'b0;
      @(negedge aclk);
      check("b0_rready_lo", {60'd0, ds_rready}, 64'h0);
      check("b0_arready", {63'd0, us_arready}, 64'd0);
      step();
      us_rready = 1'b1;
      @(negedge aclk);
      check("b0_rready_hi", {60'd0, ds_rready}, 64'h1);
      check("b0_rdata", {32'd0, us_rdata}, 64'h1000_0000 + 64'(i));
      check("b0_rlast", {63'd0, us_rlast}, (i == 7) ? 64'd1 : 64'd0);
      if (us_rvalid && us_rready) beats++;
      step();
    end
    clear_slaves();
    check("b0_beats", 64'(beats), 64'd8);
    @(negedge aclk);
    check("b0_done_busy", {63'd0, busy}, 64'd0);
    step();

    // Slave 1 active while slave 3 raises a spurious beat
    do_ar(4'hA, 32'h1000_0000, 8'd0, 4'b0010);
    ds_rvalid = 4'b1010; ds_rlast = 4'b1010;
    ds_rdata[1*32 +: 32] = 32'h1111_2222; ds_rdata[3*32 +: 32] = 32'hDEAD_BEEF;
    ds_rid[1*4 +: 4] = 4'hA; ds_rid[3*4 +: 4] = 4'hF;
    ds_rresp[1*2 +: 2] = 2'b00; ds_rresp[3*2 +: 2] = 2'b10;
    us_rready = 1'b1;
    @(negedge aclk);
    check("s1_rdata", {32'd0, us_rdata}, 64'h1111_2222);
    check("s1_rid", {60'd0, us_rid}, 64'hA);
    check("s1_rresp", {62'd0, us_rresp}, 64'd0);
    check("s1_rready", {60'd0, ds_rready}, 64'h2);
    step();
    clear_slaves();

    // Unmapped index 5, arlen 3
`ifdef AXI_RD_ROUTER_DECERR_EN
    us_arid = 4'h3; us_araddr = 32'h5000_0000; us_arlen = 8'd3; us_arvalid = 1'b1;
    @(negedge aclk);
    check("err_arready", {63'd0, us_arready}, 64'd1);
    step();
    us_arvalid = 1'b0;
    us_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("err_arvalid", {60'd0, ds_arvalid}, 64'h0);
      check("err_rvalid", {63'd0, us_rvalid}, 64'd1);
      check("err_rresp", {62'd0, us_rresp}, 64'h3);
      check("err_rdata", {32'd0, us_rdata}, 64'h0);
      check("err_rid", {60'd0, us_rid}, 64'h3);
      check("err_rlast", {63'd0, us_rlast}, (i == 3) ? 64'd1 : 64'd0);
      step();
    end
    @(negedge aclk);
    check("err_done_busy", {63'd0, busy}, 64'd0);
    step();
`else
    do_ar(4'h3, 32'h5000_0000, 8'd3, 4'b1000);
    ds_rvalid = 4'b1000; ds_rlast = 4'b1000; ds_rdata[3*32 +: 32] = 32'h0000_5555;
    us_rready = 1'b1;
    @(negedge aclk);
    check("def_rdata", {32'd0, us_rdata}, 64'h5555);
    check("def_rready", {60'd0, ds_rready}, 64'h8);
    step();
    clear_slaves();
`endif

    // Reset during DATA after two of eight beats
    do_ar(4'h2, 32'h0000_0200, 8'd7, 4'b0001);
    ds_rvalid = 4'b0001;
    us_rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ds_rdata[31:0] = 32'h2000_0000 + i;
      @(negedge aclk);
      check("mr_rdata", {32'd0, us_rdata}, 64'h2000_0000 + 64'(i));
      step();
    end
    areset = 1'b1;
    @(negedge aclk);
    check("mr_rst_busy", {63'd0, busy}, 64'd0);
    check("mr_rst_rready", {60'd0, ds_rready}, 64'h0);
    step();
    areset = 1'b0;
    @(negedge aclk);
    check("mr_post_busy", {63'd0, busy}, 64'd0);
    check("mr_post_rready", {60'd0, ds_rready}, 64'h0);
    step();
    clear_slaves();
    do_ar(4'h7, 32'h2000_0000, 8'd0, 4'b0100);
    ds_rvalid = 4'b0100; ds_rlast = 4'b0100; ds_rdata[2*32 +: 32] = 32'h7777_0000;
    @(negedge aclk);
    check("mr_new_rdata", {32'd0, us_rdata}, 64'h7777_0000);
    step();
    clear_slaves();
    @(negedge aclk);
    check("mr_new_idle", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
